// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_ctrl
// Purpose  : Frame sequencer for a rate-1/2, K=3 convolutional encoder.
//            Serialises bytes MSB first over two-clock bit periods, then
//            appends zero tail bits.
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_ctrl #(
    parameter int LEN_W = 8,
    parameter int TAIL  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             enc_clr,
    output logic             enc_en,
    output logic             enc_x,
    output logic             enc_phase,
    output logic             enc_tail,
    output logic             done
);

    localparam int              TC_W        = $clog2(2*TAIL+1);
    localparam logic [TC_W-1:0] C_TAIL_LAST = TC_W'(2*TAIL-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [7:0]       r_shreg,    w_shreg_nxt;
    logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
    logic [2:0]       r_bit_cnt,  w_bit_cnt_nxt;
    logic             r_phase,    w_phase_nxt;
    logic [TC_W-1:0]  r_tail_cnt, w_tail_cnt_nxt;
    logic             w_capture;
    logic             w_enc_act;

    logic r_din_ready, r_busy, r_enc_clr, r_enc_en;
    logic r_enc_x, r_enc_phase, r_enc_tail, r_done;

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_byte_cnt_nxt = r_byte_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_phase_nxt    = r_phase;
        w_tail_cnt_nxt = r_tail_cnt;
        w_capture      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (frame_len != '0)) begin
                    w_byte_cnt_nxt = frame_len;
                    w_state_nxt    = S_CLR;
                end
            end
            S_CLR: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (din_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    if (r_bit_cnt == 3'd0) begin
                        if (r_byte_cnt == '0) begin
                            w_state_nxt    = S_TAIL;
                            w_tail_cnt_nxt = '0;
                        end else if (din_valid) begin
                            // Back-to-back byte: reload without a bubble
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = S_LOAD;
                        end
                    end
                end
            end
            S_TAIL: begin
                w_phase_nxt    = ~r_phase;
                w_tail_cnt_nxt = r_tail_cnt + TC_W'(1);
                if (r_tail_cnt == C_TAIL_LAST) begin
                    w_tail_cnt_nxt = '0;
                    w_state_nxt    = S_DONE;
                end
            end
            S_DONE: begin
                w_phase_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_capture) begin
            w_shreg_nxt    = din;
            w_bit_cnt_nxt  = 3'd7;
            w_phase_nxt    = 1'b0;
            w_byte_cnt_nxt = r_byte_cnt - LEN_W'(1);
        end
    end

    assign w_enc_act = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_TAIL);

    // Outputs are registered from the next-state decode so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_phase     <= 1'b0;
            r_tail_cnt  <= '0;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_enc_clr   <= 1'b0;
            r_enc_en    <= 1'b0;
            r_enc_x     <= 1'b0;
            r_enc_phase <= 1'b0;
            r_enc_tail  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_tail_cnt  <= w_tail_cnt_nxt;
            r_din_ready <= (w_state_nxt == S_LOAD) ||
                           ((w_state_nxt == S_SHIFT) && (w_bit_cnt_nxt == 3'd0) &&
                            w_phase_nxt && (w_byte_cnt_nxt != '0));
            r_busy      <= (w_state_nxt != S_IDLE);
            r_enc_clr   <= (w_state_nxt == S_CLR);
            r_enc_en    <= w_enc_act;
            r_enc_x     <= (w_state_nxt == S_SHIFT) && w_shreg_nxt[7];
            r_enc_phase <= w_enc_act && w_phase_nxt;
            r_enc_tail  <= (w_state_nxt == S_TAIL);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign enc_clr   = r_enc_clr;
    assign enc_en    = r_enc_en;
    assign enc_x     = r_enc_x;
    assign enc_phase = r_enc_phase;
    assign enc_tail  = r_enc_tail;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the rate-1/2, K=3 convolutional encoder. It accepts a frame of parallel bytes from an upstream source over a valid/ready handshake and clears the encoder state at frame start. It feeds the encoder one bit, MSB first, per two-clock bit period, which matches the encoder's two code bits per input bit. After the data it appends K-1 zero tail bits to terminate the trellis, then signals frame completion.

## Interface
- LEN_W, 8, width of the frame-length field, counted in bytes
- TAIL, 2, number of zero flush bits after the data (K-1)
- clk  in  1  system clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame start request, sampled in IDLE only
- frame_len  in  LEN_W  frame length in bytes, sampled with start
- din  in  8  data byte
- din_valid  in  1  din holds a valid byte
- din_ready  out  1  controller accepts din this cycle
- busy  out  1  high from the cycle after start is accepted through the done cycle
- enc_clr  out  1  one-cycle pulse that clears the encoder state to s0
- enc_en  out  1  the encoder consumes enc_x in this cycle
- enc_x  out  1  encoder input bit, held for both phases of a bit period
- enc_phase  out  1  0 = first code-bit cycle, 1 = second code-bit cycle
- enc_tail  out  1  the current bit period is a tail bit
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, CLR, LOAD, SHIFT, TAIL, DONE.
- IDLE
  - All outputs are 0.
  - start=1 with frame_len≠0: latch frame_len into byte_cnt, go to CLR.
  - start with frame_len=0 is ignored.
  - start in any other state is ignored.
- CLR
  - enc_clr=1 for exactly one cycle, then go to LOAD.
- LOAD
  - din_ready=1, enc_en=0.
  - On din_valid: capture din into an 8-bit shift register, bit_cnt=7, phase=0, byte_cnt−1, go to SHIFT.
  - The controller waits in LOAD indefinitely; there is no timeout.
- SHIFT
  - enc_en=1, enc_x=shreg[7], enc_phase=phase; phase toggles every cycle.
  - On phase=1: shift shreg left by 1 and decrement bit_cnt.
  - On the last cycle of a byte (bit_cnt=0, phase=1):
    - byte_cnt=0: go to TAIL.
    - Otherwise din_ready=1. If din_valid, capture the next byte and stay in SHIFT with no bubble. If not, go to LOAD.
  - din_ready is 0 in every other SHIFT cycle.
- TAIL
  - enc_en=1, enc_x=0, enc_tail=1, phase toggles every cycle.
  - Lasts 2·TAIL cycles, then go to DONE.
- DONE
  - done=1 and busy=1 for one cycle, then go to IDLE.
- Counters
  - byte_cnt is LEN_W bits and never wraps, because frame_len=0 is rejected.
  - The tail counter is $clog2(2·TAIL+1) bits.
- Output timing: all outputs are decoded from registered state and counters. No input reaches an output combinationally, except that din_ready depends on state and counters only.
- Reset
  - Assertion at any time, including mid-frame, forces IDLE immediately.
  - Every output goes to 0; shreg, byte_cnt, bit_cnt, phase and the tail counter clear.
  - A partially sent frame is abandoned with no done pulse.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Cycle 1: CLR.
- Cycle 2: LOAD; the first byte is accepted here if din_valid=1.
- Zero-stall frame of N bytes:
  - SHIFT occupies cycles 3 … 16N+2.
  - TAIL occupies cycles 16N+3 … 16N+2+2·TAIL.
  - done is asserted in cycle 16N+3+2·TAIL, which is 16N+7 for TAIL=2.
- Next-byte accept points: byte k is accepted in cycle 2+16(k−1), k≥1, given no stalls.
- Stall: if byte k becomes valid d cycles after its accept point, the controller sits in LOAD for d cycles.
  - enc_en=0 during those d cycles.
  - done is delayed by exactly d cycles.
- busy rises in cycle 1 and falls after the done cycle.
- start may be reissued in the cycle after done.

## Test plan
- Reset and idle:
  - Assert reset low mid-simulation: every output reads 0.
  - Release reset with start=0: outputs stay 0 and busy=0.
- Single byte, frame_len=1, din=8'hB4, din_valid held high:
  - enc_clr high in cycle 1, din_ready high in cycle 2.
  - enc_x over cycles 3–18 reads 1,1,0,0,1,1,1,1,0,0,1,1,0,0,0,0.
  - Cycles 19–22: enc_tail=1, enc_x=0.
  - done high in cycle 23.
- Three bytes back-to-back (8'hFF, 8'h00, 8'hA5):
  - din_ready high only in cycles 2, 18 and 34.
  - enc_en continuously high over cycles 3–54.
  - done high in cycle 55.
- Mid-frame stall: same three bytes, but the second byte is presented 5 cycles late.
  - LOAD occupies cycles 19–23 with enc_en=0.
  - The second byte is accepted in cycle 23.
  - done high in cycle 60.
- Rejected starts:
  - start with frame_len=0: state remains IDLE, busy=0, enc_clr never pulses.
  - start pulsed during SHIFT of a 2-byte frame: ignored, done occurs only once, in cycle 39.
- Reset mid-frame:
  - Assert reset in cycle 10 of a 1-byte frame: all outputs 0 immediately, no done pulse.
  - A new start after release reproduces the single-byte timing exactly.
